pt_tx_sched: RTL

//  Shares one PT2262 frame encoder (pt_enc) between two codeword requesters.

---
 rtl/pt_tx_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pt_tx_sched.sv
// Round-robin scheduler that shares one PT2262 frame encoder between two requesters.
// Each accepted codeword goes out as N_REPEAT frames, and every frame is followed by GAP_CYCLES of idle line.
module pt_tx_sched #(
    parameter int N_REPEAT    = 4,
    parameter int GAP_CYCLES  = 40,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [23:0] req0_code,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_code,
    output logic        req1_ready,
    output logic        pt_ld,
    output logic [23:0] pt_ad,
    input  logic        pt_done,
    output logic        busy,
    output logic        grant_id,
    output logic        err_timeout
);

    localparam int RW = $clog2(N_REPEAT + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [RW-1:0] REP_LAST = RW'(N_REPEAT - 1);
    localparam logic [RW-1:0] REP_FULL = RW'(N_REPEAT);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic            rr_ptr;
    logic [RW-1:0]   rep_cnt;
    logic [TW-1:0]   to_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            take;
    logic            pick1;

    // When both requesters are valid, the requester named by the round-robin pointer wins.
    assign pick1 = req1_valid & (~req0_valid | rr_ptr);
    assign take  = (state == S_IDLE) & (req0_valid | req1_valid);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment at the top keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (take) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (pt_done) state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!pt_done)               state_nxt = S_WAIT_DONE;
                else if (to_cnt == TO_LAST) state_nxt = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (pt_done) begin
                    if (GAP_CYCLES > 0)           state_nxt = S_GAP;
                    else if (rep_cnt == REP_LAST) state_nxt = S_IDLE;
                    else                          state_nxt = S_LOAD;
                end
            end
            S_GAP: begin
                // rep_cnt was already advanced when the frame finished.
                if (gap_cnt == GAP_LAST) state_nxt = (rep_cnt == REP_FULL) ? S_IDLE : S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = take & ~pick1;
        req1_ready = take & pick1;
        pt_ld      = (state == S_LOAD) & pt_done;
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_ad       <= '0;
            grant_id    <= 1'b0;
            rr_ptr      <= 1'b0;
            rep_cnt     <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        pt_ad    <= pick1 ? req1_code : req0_code;
                        grant_id <= pick1;
                        rr_ptr   <= ~pick1;
                        rep_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (pt_done) to_cnt <= '0;
                end
                S_WAIT_START: begin
                    if (pt_done) begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TO_LAST) err_timeout <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (pt_done) begin
                        rep_cnt <= rep_cnt + 1'b1;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
